// File: rtl/xc_rf_param.sv
// Parameterised multi-port register file with pair writes, a pending-bit
// scoreboard and a post-reset scrub that zeroes every entry before use.
module xc_rf_param #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 3,
    parameter int RD_REG = 0,
    localparam int AW    = $clog2(NREGS),
    localparam int IW    = AW - 1,
    localparam int HN    = NREGS / 2
) (
    input  logic                clk,
    input  logic                srst,
    output logic                busy,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_rdata,
    output logic [NRD-1:0]      rs_pend,
    input  logic                rd_wen,
    input  logic                rd_wide,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd_wdata,
    input  logic [XLEN-1:0]     rd_wdata_hi,
    output logic                wr_err,
    input  logic                lock_en,
    input  logic                lock_wide,
    input  logic [AW-1:0]       lock_addr
);

    typedef enum logic {IDLE, SCRUB} state_t;

    state_t            state_reg;
    logic [IW-1:0]     scrub_idx_reg;
    logic              wr_err_reg;
    logic [NREGS-1:0]  pend_reg;
    logic [NREGS-1:0]  pend_next;
    logic [NREGS-1:0]  wr_mask;
    logic [NREGS-1:0]  lk_mask;

    logic [XLEN-1:0]   even_mem [HN];
    logic [XLEN-1:0]   odd_mem  [HN];

    logic              scrubbing;
    logic              scrub_we;
    logic              wr_ok;
    logic              even_we;
    logic              odd_we;
    logic              lk_ok;
    logic [IW-1:0]     wr_idx;
    logic [XLEN-1:0]   odd_wdata;

    assign scrubbing = (state_reg == SCRUB);
    assign scrub_we  = scrubbing && !srst;
    assign busy      = srst || scrubbing;
    assign wr_err    = wr_err_reg;

    // A wide write is only legal on an even address; odd pair writes are dropped.
    assign wr_ok     = !busy && rd_wen && !(rd_wide && rd_addr[0]);
    assign wr_idx    = rd_addr[AW-1:1];
    assign even_we   = wr_ok && (rd_wide || !rd_addr[0]) && (rd_addr != '0);
    assign odd_we    = wr_ok && (rd_wide || rd_addr[0]);
    assign odd_wdata = rd_wide ? rd_wdata_hi : rd_wdata;
    assign lk_ok     = !busy && lock_en && !(lock_wide && lock_addr[0]);

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg     <= SCRUB;
            scrub_idx_reg <= '0;
            wr_err_reg    <= 1'b0;
            pend_reg      <= '0;
        end else begin
            wr_err_reg <= !scrubbing && rd_wen && rd_wide && rd_addr[0];
            pend_reg   <= pend_next;
            case (state_reg)
                SCRUB: begin
                    scrub_idx_reg <= scrub_idx_reg + IW'(1);
                    if (scrub_idx_reg == IW'(HN - 1)) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (scrub_we) begin
            even_mem[scrub_idx_reg] <= '0;
        end else if (even_we) begin
            even_mem[wr_idx] <= rd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (scrub_we) begin
            odd_mem[scrub_idx_reg] <= '0;
        end else if (odd_we) begin
            odd_mem[wr_idx] <= odd_wdata;
        end
    end

    // Locks are applied after write clears so a same-cycle lock keeps the bit set.
    always_comb begin
        wr_mask = '0;
        lk_mask = '0;
        if (even_we) wr_mask[{wr_idx, 1'b0}] = 1'b1;
        if (odd_we)  wr_mask[{wr_idx, 1'b1}] = 1'b1;
        if (lk_ok) begin
            lk_mask[lock_addr] = 1'b1;
            if (lock_wide) lk_mask[{lock_addr[AW-1:1], 1'b1}] = 1'b1;
        end
        pend_next = (pend_reg & ~wr_mask) | lk_mask;
        if (scrub_we) begin
            pend_next[{scrub_idx_reg, 1'b0}] = 1'b0;
            pend_next[{scrub_idx_reg, 1'b1}] = 1'b0;
        end
        pend_next[0] = 1'b0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [AW-1:0]   a;
            logic [XLEN-1:0] comb_data;
            logic [XLEN-1:0] data_sel;
            logic            pend_sel;

            assign a         = rs_addr[gi*AW +: AW];
            assign comb_data = (a == '0) ? '0 :
                               (a[0] ? odd_mem[a[AW-1:1]] : even_mem[a[AW-1:1]]);

            if (RD_REG != 0) begin : g_reg
                logic [XLEN-1:0] fwd_data;
                logic [XLEN-1:0] data_reg;
                logic            pend_bit_reg;

                // Write-first: data landing at this edge replaces the stale array value.
                assign fwd_data = (even_we && (a == {wr_idx, 1'b0})) ? rd_wdata  :
                                  (odd_we  && (a == {wr_idx, 1'b1})) ? odd_wdata :
                                  comb_data;

                always_ff @(posedge clk) begin
                    if (busy) begin
                        data_reg     <= '0;
                        pend_bit_reg <= 1'b0;
                    end else begin
                        data_reg     <= fwd_data;
                        pend_bit_reg <= pend_next[a];
                    end
                end

                assign data_sel = data_reg;
                assign pend_sel = pend_bit_reg;
            end else begin : g_comb
                assign data_sel = comb_data;
                assign pend_sel = pend_reg[a];
            end

            assign rs_rdata[gi*XLEN +: XLEN] = busy ? '0 : data_sel;
            assign rs_pend[gi]               = busy ? 1'b0 : pend_sel;
        end
    endgenerate

endmodule

// File: tb/tb_xc_rf_param.sv
// Randomised and directed bench for xc_rf_param; one instance per read mode,
// both compared every cycle against an array-based architectural model.
module tb_xc_rf_param;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 3;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                srst;
    logic                rd_wen, rd_wide, lock_en, lock_wide;
    logic [AW-1:0]       rd_addr, lock_addr;
    logic [XLEN-1:0]     rd_wdata, rd_wdata_hi;
    logic [NRD*AW-1:0]   rs_addr;
    logic                busy0, busy1, wr_err0, wr_err1;
    logic [NRD*XLEN-1:0] rdata0, rdata1;
    logic [NRD-1:0]      pend0, pend1;

    xc_rf_param #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .RD_REG(0)) dut0 (
        .clk(clk), .srst(srst), .busy(busy0), .rs_addr(rs_addr), .rs_rdata(rdata0),
        .rs_pend(pend0), .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr),
        .rd_wdata(rd_wdata), .rd_wdata_hi(rd_wdata_hi), .wr_err(wr_err0),
        .lock_en(lock_en), .lock_wide(lock_wide), .lock_addr(lock_addr)
    );

    xc_rf_param #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .RD_REG(1)) dut1 (
        .clk(clk), .srst(srst), .busy(busy1), .rs_addr(rs_addr), .rs_rdata(rdata1),
        .rs_pend(pend1), .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr),
        .rd_wdata(rd_wdata), .rd_wdata_hi(rd_wdata_hi), .wr_err(wr_err1),
        .lock_en(lock_en), .lock_wide(lock_wide), .lock_addr(lock_addr)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Architectural model: plain register array, pending flags, scrub progress.
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_pend [NREGS];
    bit              m_scrub;
    int              m_idx;
    bit              m_werr;
    logic [XLEN-1:0] e1_data [NRD];
    bit              e1_pend [NRD];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [XLEN-1:0] m_read(input int a);
        return (a == 0) ? '0 : m_mem[a];
    endfunction

    task automatic idle();
        rd_wen = 1'b0; rd_wide = 1'b0; rd_addr = '0; rd_wdata = '0; rd_wdata_hi = '0;
        lock_en = 1'b0; lock_wide = 1'b0; lock_addr = '0;
    endtask

    task automatic raddr(input int a0, input int a1, input int a2);
        rs_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic wr(input int a, input logic [XLEN-1:0] d, input logic wide, input logic [XLEN-1:0] hi);
        rd_wen = 1'b1; rd_wide = wide; rd_addr = AW'(a); rd_wdata = d; rd_wdata_hi = hi;
    endtask

    task automatic lk(input int a, input logic wide);
        lock_en = 1'b1; lock_wide = wide; lock_addr = AW'(a);
    endtask

    task automatic model_edge();
        bit pre;
        int a;
        pre = srst || m_scrub;
        if (srst) begin
            m_scrub = 1'b1; m_idx = 0; m_werr = 1'b0;
        end else if (m_scrub) begin
            m_mem[2*m_idx] = '0; m_mem[2*m_idx+1] = '0;
            m_pend[2*m_idx] = 1'b0; m_pend[2*m_idx+1] = 1'b0;
            m_idx++;
            if (m_idx == NREGS/2) m_scrub = 1'b0;
            m_werr = 1'b0;
        end else begin
            a = int'(rd_addr);
            m_werr = rd_wen && rd_wide && (a % 2 == 1);
            if (rd_wen && !m_werr) begin
                m_mem[a] = rd_wdata; m_pend[a] = 1'b0;
                if (rd_wide) begin
                    m_mem[a+1] = rd_wdata_hi; m_pend[a+1] = 1'b0;
                end
            end
            if (lock_en) begin
                a = int'(lock_addr);
                if (!lock_wide) m_pend[a] = 1'b1;
                else if (a % 2 == 0) begin
                    m_pend[a] = 1'b1; m_pend[a+1] = 1'b1;
                end
            end
            m_mem[0] = '0; m_pend[0] = 1'b0;
        end
        for (int k = 0; k < NRD; k++) begin
            a = int'(rs_addr[k*AW +: AW]);
            e1_data[k] = pre ? '0 : m_read(a);
            e1_pend[k] = pre ? 1'b0 : m_pend[a];
        end
    endtask

    // One transaction: check all outputs mid-cycle, then advance one clock.
    task automatic cycle();
        bit bz;
        int a;
        #1;
        bz = srst || m_scrub;
        check("busy0", 64'(busy0), 64'(bz));
        check("busy1", 64'(busy1), 64'(bz));
        check("wr_err0", 64'(wr_err0), 64'(m_werr));
        check("wr_err1", 64'(wr_err1), 64'(m_werr));
        for (int k = 0; k < NRD; k++) begin
            a = int'(rs_addr[k*AW +: AW]);
            check($sformatf("rdata0[%0d] a=%0d", k, a), 64'(rdata0[k*XLEN +: XLEN]), 64'(bz ? '0 : m_read(a)));
            check($sformatf("pend0[%0d] a=%0d", k, a), 64'(pend0[k]), 64'(bz ? 1'b0 : m_pend[a]));
            check($sformatf("rdata1[%0d]", k), 64'(rdata1[k*XLEN +: XLEN]), 64'(bz ? '0 : e1_data[k]));
            check($sformatf("pend1[%0d]", k), 64'(pend1[k]), 64'(bz ? 1'b0 : e1_pend[k]));
        end
        $display("cyc %0d srst=%0b busy=%0b wen=%0b wide=%0b wa=%0d wd=%h lk=%0b lkw=%0b la=%0d ra=%0d/%0d/%0d",
                 cyc, srst, busy0, rd_wen, rd_wide, rd_addr, rd_wdata, lock_en, lock_wide, lock_addr,
                 rs_addr[0 +: AW], rs_addr[AW +: AW], rs_addr[2*AW +: AW]);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
    endtask

    task automatic random_inputs();
        rd_wen      = 1'($urandom_range(0, 1));
        rd_wide     = ($urandom_range(0, 2) == 0);
        rd_addr     = AW'($urandom_range(0, NREGS-1));
        rd_wdata    = $urandom;
        rd_wdata_hi = $urandom;
        lock_en     = ($urandom_range(0, 3) == 0);
        lock_wide   = 1'($urandom_range(0, 1));
        lock_addr   = AW'($urandom_range(0, NREGS-1));
        raddr($urandom_range(0, NREGS-1), $urandom_range(0, NREGS-1), $urandom_range(0, NREGS-1));
    endtask

    initial begin
        int n;
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i] = '0; m_pend[i] = 1'b0;
        end
        for (int k = 0; k < NRD; k++) begin
            e1_data[k] = '0; e1_pend[k] = 1'b0;
        end
        m_scrub = 1'b1; m_idx = 0; m_werr = 1'b0;
        srst = 1'b1;
        idle();
        raddr(0, 0, 0);
        @(negedge clk);

        // Reset for 2 cycles, then count scrub cycles.
        cycle(); cycle();
        srst = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (busy0 && n < 40);
        check("busy_len_after_reset", 64'(n), 64'd16);

        for (int b = 0; b < NREGS; b += NRD) begin
            raddr(b % NREGS, (b+1) % NREGS, (b+2) % NREGS);
            cycle();
        end

        // Wide write to an even pair.
        idle(); raddr(3, 4, 5);
        wr(4, 32'hA5A5A5A5, 1'b1, 32'h5A5A5A5A);
        cycle();
        idle();
        #1;
        check("reg4", 64'(rdata0[XLEN +: XLEN]), 64'h0000_0000_A5A5_A5A5);
        check("reg5", 64'(rdata0[2*XLEN +: XLEN]), 64'h0000_0000_5A5A_5A5A);
        check("reg3", 64'(rdata0[0 +: XLEN]), 64'h0);
        check("reg4_bypass", 64'(rdata1[XLEN +: XLEN]), 64'h0000_0000_A5A5_A5A5);
        cycle();
        raddr(6, 4, 5);
        cycle();

        // Odd wide write is rejected with a one-cycle wr_err.
        idle(); wr(7, 32'h77, 1'b0, '0); cycle();
        idle(); wr(8, 32'h88, 1'b0, '0); cycle();
        idle(); raddr(7, 8, 0);
        wr(7, 32'hDEADDEAD, 1'b1, 32'hBEEFBEEF);
        cycle();
        idle();
        #1;
        check("werr_pulse", 64'(wr_err0), 64'd1);
        check("reg7_kept", 64'(rdata0[0 +: XLEN]), 64'h77);
        check("reg8_kept", 64'(rdata0[XLEN +: XLEN]), 64'h88);
        cycle();
        #1;
        check("werr_one_cycle", 64'(wr_err0), 64'd0);

        // Registered-read bypass, narrow and hi half of a wide write.
        idle(); raddr(9, 0, 0);
        wr(9, 32'h12345678, 1'b0, '0);
        cycle();
        idle();
        #1;
        check("bypass9", 64'(rdata1[0 +: XLEN]), 64'h1234_5678);
        idle(); raddr(13, 12, 0);
        wr(12, 32'hC0FFEE00, 1'b1, 32'h0BADF00D);
        cycle();
        idle();
        #1;
        check("bypass13_hi", 64'(rdata1[0 +: XLEN]), 64'h0BAD_F00D);
        check("bypass12_lo", 64'(rdata1[XLEN +: XLEN]), 64'hC0FF_EE00);

        // Scoreboard: wide lock, clear by write, lock beats write.
        idle(); raddr(10, 11, 12);
        lk(10, 1'b1);
        cycle();
        idle();
        #1;
        check("pend_10_11", 64'(pend0), 64'b011);
        check("pend1_10_11", 64'(pend1), 64'b011);
        wr(11, 32'h11, 1'b0, '0);
        cycle();
        idle();
        #1;
        check("pend_after_w11", 64'(pend0), 64'b001);
        lk(10, 1'b0); wr(10, 32'hAA, 1'b0, '0);
        cycle();
        idle();
        #1;
        check("lock_wins", 64'(pend0), 64'b001);
        check("lock_wins_data", 64'(rdata0[0 +: XLEN]), 64'hAA);

        // Register 0 ignores writes and locks; wide ops at 0 still reach register 1.
        idle(); raddr(0, 1, 2);
        wr(0, 32'hFFFFFFFF, 1'b0, '0); lk(0, 1'b0);
        cycle();
        idle();
        #1;
        check("reg0_data", 64'(rdata0[0 +: XLEN]), 64'h0);
        check("reg0_pend", 64'(pend0[0]), 64'd0);
        wr(0, 32'hFFFFFFFF, 1'b1, 32'h0101_0101); lk(0, 1'b1);
        cycle();
        idle();
        #1;
        check("reg0_wide_data", 64'(rdata0[0 +: XLEN]), 64'h0);
        check("reg1_wide_data", 64'(rdata0[XLEN +: XLEN]), 64'h0101_0101);
        check("reg0_wide_pend", 64'(pend0), 64'b010);
        cycle();

        // Reset reasserted at scrub index 5 restarts the full scrub.
        srst = 1'b1; cycle();
        srst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            random_inputs(); cycle();
        end
        srst = 1'b1; cycle();
        srst = 1'b0;
        n = 0;
        do begin
            random_inputs();
            cycle();
            n++;
        end while (busy0 && n < 40);
        check("busy_len_mid_reset", 64'(n), 64'd16);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            random_inputs();
            srst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        srst = 1'b0;
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xc_rf_param.md
XC_RF_PARAM -- requirements
Module: xc_rf_param

Interface
REQ-001 SHALL have parameter XLEN, default 32, register width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, 4..64; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 3, read-port count, 1..6.
REQ-004 SHALL have parameter RD_REG, default 0: 0 = combinational read, 1 = registered read (one-cycle latency).
REQ-005 SHALL use one clock and a synchronous active-high reset: clock in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-006 SHALL have port: busy  out  1  scrub in progress; writes and locks are ignored.
REQ-007 SHALL have port: rs_addr  in  NRD*AW  packed read addresses, port k at bits [k*AW +: AW].
REQ-008 SHALL have port: rs_rdata  out  NRD*XLEN  packed read data, port k at bits [k*XLEN +: XLEN].
REQ-009 SHALL have port: rs_pend  out  NRD  pending (locked) flag of each addressed register.
REQ-010 SHALL have ports: rd_wen  in  1  write enable; rd_wide  in  1  pair write; rd_addr  in  AW; rd_wdata  in  XLEN; rd_wdata_hi  in  XLEN.
REQ-011 SHALL have port: wr_err  out  1  registered one-cycle pulse flagging a rejected write.
REQ-012 SHALL have ports: lock_en  in  1; lock_wide  in  1; lock_addr  in  AW; they mark destination(s) pending.

Function
REQ-013 SHALL store registers in an even bank and an odd bank of NREGS/2 entries each, both indexed by addr[AW-1:1]; addr[0]=0 selects even, addr[0]=1 selects odd.
REQ-014 SHALL read register 0 as zero on every port; a write or lock to register 0 alone SHALL have no effect.
REQ-015 SHALL, for a narrow write (rd_wen=1, rd_wide=0), write rd_wdata to rd_addr at the clock edge.
REQ-016 SHALL, for a wide write with even rd_addr, write rd_wdata to rd_addr and rd_wdata_hi to rd_addr+1 at the same edge; register 0 stays zero, register 1 is still written.
REQ-017 SHALL reject a wide write with odd rd_addr: no register changes, and wr_err=1 in the next cycle.
REQ-018 SHALL, with RD_REG=0, make rs_rdata combinational from the current array; a same-cycle write is not visible until after the edge.
REQ-019 SHALL, with RD_REG=1, capture rs_addr at edge N and present the data at edge N; a write at edge N SHALL bypass into the captured data (write-first), including the hi half of a wide write.
REQ-020 SHALL keep a pending bit per register; lock_en sets the bit of lock_addr, and lock_wide with even lock_addr also sets lock_addr+1; lock_wide with odd lock_addr SHALL set nothing.
REQ-021 SHALL clear the pending bit(s) of every register written by an accepted write.
REQ-022 SHALL leave the bit set when a lock and a write hit the same register in the same cycle (lock wins).
REQ-023 SHALL drive rs_pend[k] as the pending bit of rs_addr port k, with the same latency as rs_rdata (it follows RD_REG); register 0 is never pending.
REQ-024 SHALL implement a scrub FSM with states IDLE and SCRUB: reset enters SCRUB with a pair counter of 0; each SCRUB cycle zeroes both bank entries and the pending bits at that index and increments the counter; after index NREGS/2-1 the FSM moves to IDLE.
REQ-025 SHALL hold busy=1 exactly during SCRUB (NREGS/2 cycles after reset deasserts) and SHALL return zero data and zero pending on all ports while busy.
REQ-026 SHALL discard writes and locks presented while busy, without wr_err.
REQ-027 SHALL restart the scrub at index 0 if reset is reasserted mid-scrub.

Reset
REQ-028 SHALL, while reset=1, drive busy=1, wr_err=0, rs_rdata=0, rs_pend=0, scrub counter=0, state SCRUB.
REQ-029 SHALL have every register and pending bit equal to 0 when busy first falls after reset.

Verification
REQ-030 SHALL cover reset: reset for 2 cycles then release, default parameters -> busy high for 16 cycles, then low; all reads return 0x00000000.
REQ-031 SHALL cover wide write: rd_addr=4, wide, wdata=0xA5A5A5A5, hi=0x5A5A5A5A -> reg4=0xA5A5A5A5, reg5=0x5A5A5A5A; regs 3 and 6 unchanged.
REQ-032 SHALL cover odd wide write: rd_addr=7, wide -> wr_err pulse for 1 cycle; reg7 and reg8 unchanged.
REQ-033 SHALL cover bypass with RD_REG=1: read address 9 in the same cycle as a write of 0x12345678 to 9 -> rs_rdata=0x12345678 the next cycle.
REQ-034 SHALL cover scoreboard: lock reg 10 wide -> rs_pend set for 10 and 11; narrow write to 11 -> only 10 pending; simultaneous lock and write to 10 -> 10 stays pending.
REQ-035 SHALL cover mid-scrub reset: reassert reset at scrub index 5 -> busy stays high for 16 further cycles; writing 0 to reg0 and locking reg0 have no effect at any time.
